// File: rtl/counter_axi_regs.sv
// counter_axi_regs: AXI4-Lite register block at the processor end of the
// counter datapath. Drives sw_out into the counter and exposes a live count
// (COUNT), a captured snapshot (SNAP) and an LED rising-edge tally (LEDCNT).
// Ports: clk, rst (async, active high); AXI4-Lite AW/W/B/AR/R slave channels;
//        counter_in, led_in from the counter; sw_out to the counter;
//        irq (only when COUNTER_AXI_REGS_IRQ_EN is defined).
// Optional macro COUNTER_AXI_REGS_IRQ_EN adds the IRQ register at 0x14.
module counter_axi_regs #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [DATA_WIDTH-1:0]   counter_in,
    input  logic                    led_in,
    output logic [3:0]              sw_out
`ifdef COUNTER_AXI_REGS_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] R_CTRL   = IW'(0);
    localparam logic [IW-1:0] R_COUNT  = IW'(1);
    localparam logic [IW-1:0] R_SNAP   = IW'(2);
    localparam logic [IW-1:0] R_CMD    = IW'(3);
    localparam logic [IW-1:0] R_LEDCNT = IW'(4);
`ifdef COUNTER_AXI_REGS_IRQ_EN
    localparam logic [IW-1:0] R_IRQ    = IW'(5);
`endif
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [IW-1:0]         aw_idx_q, aw_idx_d;
    logic [3:0]            wdat_q, wdat_d;
    logic                  wstb_q, wstb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] snap_q, snap_d, ledcnt_q, ledcnt_d;
    logic                  led_q, led_d;
`ifdef COUNTER_AXI_REGS_IRQ_EN
    logic                  irq_pend_q, irq_pend_d, irq_en_q, irq_en_d;
    logic                  irq_q, irq_d, pend_clr;
`endif

    logic                  aw_hs, w_hs, ar_hs, wr_fire, wr_stb, led_rise, led_clr;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [3:0]            wr_dat;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic                  unused_bits;

    assign unused_bits = ^{s_axi_wdata[DATA_WIDTH-1:4], s_axi_wstrb[3:1],
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        // Write channel: each beat is latched on its own handshake; the
        // register update fires once both are present (held or arriving).
        aw_hs     = s_axi_awvalid & awready_q;
        w_hs      = s_axi_wvalid & wready_q;
        wr_fire   = (aw_have_q | aw_hs) & (w_have_q | w_hs);
        wr_idx    = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
        wr_dat    = w_hs ? s_axi_wdata[3:0] : wdat_q;
        wr_stb    = w_hs ? s_axi_wstrb[0] : wstb_q;
        aw_idx_d  = wr_idx;
        wdat_d    = wr_dat;
        wstb_d    = wr_stb;
        aw_have_d = (aw_have_q | aw_hs) & ~wr_fire;
        w_have_d  = (w_have_q | w_hs) & ~wr_fire;
        bvalid_d  = wr_fire | (bvalid_q & ~s_axi_bready);
        bresp_d   = bresp_q;
        // Readies stay low while a beat is held or a response is pending,
        // which limits the block to one outstanding write.
        awready_d = ~aw_have_d & ~bvalid_d;
        wready_d  = ~w_have_d & ~bvalid_d;

        ctrl_d    = ctrl_q;
        snap_d    = snap_q;
        led_clr   = 1'b0;
        led_d     = led_in;
        led_rise  = led_in & ~led_q;
`ifdef COUNTER_AXI_REGS_IRQ_EN
        irq_en_d  = irq_en_q;
        pend_clr  = 1'b0;
`endif

        if (wr_fire) begin
            bresp_d = OKAY;
            case (wr_idx)
                R_CTRL: if (wr_stb) ctrl_d = wr_dat;
                R_COUNT, R_SNAP, R_LEDCNT: begin end
                R_CMD: if (wr_stb) begin
                    if (wr_dat[0]) snap_d = counter_in;
                    led_clr = wr_dat[1];
                end
`ifdef COUNTER_AXI_REGS_IRQ_EN
                R_IRQ: if (wr_stb) begin
                    pend_clr = wr_dat[0];
                    irq_en_d = wr_dat[1];
                end
`endif
                default: bresp_d = SLVERR;
            endcase
        end

        // Clear beats a coincident edge.
        if (led_clr)       ledcnt_d = '0;
        else if (led_rise) ledcnt_d = ledcnt_q + DATA_WIDTH'(1);
        else               ledcnt_d = ledcnt_q;

`ifdef COUNTER_AXI_REGS_IRQ_EN
        // A new edge beats a coincident W1C.
        irq_pend_d = led_rise | (irq_pend_q & ~pend_clr);
        irq_d      = irq_pend_d & irq_en_d;
`endif

        // Read channel: reads see the pre-update register values.
        ar_hs   = s_axi_arvalid & arready_q;
        rd_idx  = s_axi_araddr[ADDR_WIDTH-1:2];
        rd_data = '0;
        rd_resp = OKAY;
        case (rd_idx)
            R_CTRL:   rd_data = {{(DATA_WIDTH-4){1'b0}}, ctrl_q};
            R_COUNT:  rd_data = counter_in;
            R_SNAP:   rd_data = snap_q;
            R_CMD:    rd_data = '0;
            R_LEDCNT: rd_data = ledcnt_q;
`ifdef COUNTER_AXI_REGS_IRQ_EN
            R_IRQ:    rd_data = {{(DATA_WIDTH-2){1'b0}}, irq_en_q, irq_pend_q};
`endif
            default:  rd_resp = SLVERR;
        endcase
        rvalid_d  = ar_hs | (rvalid_q & ~s_axi_rready);
        rdata_d   = ar_hs ? rd_data : rdata_q;
        rresp_d   = ar_hs ? rd_resp : rresp_q;
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdat_q    <= '0;
            wstb_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ctrl_q    <= '0;
            snap_q    <= '0;
            ledcnt_q  <= '0;
            led_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_idx_q  <= aw_idx_d;
            wdat_q    <= wdat_d;
            wstb_q    <= wstb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            snap_q    <= snap_d;
            ledcnt_q  <= ledcnt_d;
            led_q     <= led_d;
        end
    end

`ifdef COUNTER_AXI_REGS_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end
    assign irq = irq_q;
`endif

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign sw_out        = ctrl_q;

endmodule
